// File: rtl/io_mmio_ctrl_pkg.sv
// Shared IO-region defines: address offsets, region tag, FIFO depth and the bus decode helper.
// Pure declarations; no state.
package io_mmio_ctrl_pkg;

   localparam logic [3:0] IO_REGION     = 4'h8;
   localparam int         IO_FIFO_DEPTH = 8;

   localparam logic [7:0] IO_UART_CTRL = 8'h00;
   localparam logic [7:0] IO_UART_RX   = 8'h04;
   localparam logic [7:0] IO_UART_TX   = 8'h08;
   localparam logic [7:0] IO_CYC_CNT   = 8'h10;
   localparam logic [7:0] IO_INST_CNT  = 8'h14;
   localparam logic [7:0] IO_CNT_RST   = 8'h18;

   typedef struct packed {
      logic       rd;
      logic       tx_push;
      logic       rx_pop_req;
      logic       cnt_clr;
      logic [7:0] off;
   } io_dec_t;

   // A write wins over a same-cycle read: the read strobe is suppressed.
   function automatic io_dec_t io_decode(input logic [3:0] tag, input logic [7:0] off,
                                         input logic [3:0] wea, input logic re);
      io_dec_t d;
      logic    hit;
      logic    wr;
      hit          = (tag == IO_REGION);
      wr           = |wea;
      d.off        = off;
      d.rd         = hit && re && !wr;
      d.tx_push    = hit && wr && (off == IO_UART_TX);
      d.rx_pop_req = d.rd && (off == IO_UART_RX);
      d.cnt_clr    = hit && wr && (off == IO_CNT_RST);
      return d;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word fall-through FIFO; head visible combinationally, push/pop take effect on the edge.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO block: UART TX/RX FIFOs plus cycle/instruction counters; dout has 1-cycle latency.
// TX stalls on tx_ready, RX backpressures via rx_ready (FIFO not full); full TX writes are dropped.
module io_mmio_ctrl
   import io_mmio_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_adr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  wea,
   input  logic        mem_re,
   input  logic        instr_retire,
   output logic [31:0] dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   io_dec_t     dec;
   logic        tx_full, tx_empty, tx_pop;
   logic        rx_full, rx_empty, rx_pop, rx_push;
   logic [7:0]  rx_head;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic [31:0] rd_dat;
   logic        unused_bits;

   assign unused_bits = ^{mem_adr[27:8], mem_wdata[31:8]};
   assign dec         = io_decode(mem_adr[31:28], mem_adr[7:0], wea, mem_re);

   assign tx_valid = !tx_empty;
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid && rx_ready;
   assign rx_pop   = dec.rx_pop_req && !rx_empty;

   io_fifo #(.WIDTH(8), .DEPTH(IO_FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset),
      .push(dec.tx_push), .push_dat(mem_wdata[7:0]),
      .pop(tx_pop), .pop_dat(tx_data),
      .full(tx_full), .empty(tx_empty)
   );

   io_fifo #(.WIDTH(8), .DEPTH(IO_FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset),
      .push(rx_push), .push_dat(rx_data),
      .pop(rx_pop), .pop_dat(rx_head),
      .full(rx_full), .empty(rx_empty)
   );

   always_comb begin
      rd_dat = '0;
      if (dec.rd) begin
         case (dec.off)
            IO_UART_CTRL: rd_dat = {30'b0, !rx_empty, !tx_full};
            IO_UART_RX:   rd_dat = rx_empty ? 32'd0 : {24'b0, rx_head};
            IO_CYC_CNT:   rd_dat = cycle_cnt;
            IO_INST_CNT:  rd_dat = instr_cnt;
            default:      rd_dat = '0;
         endcase
      end
   end

   // Counter reads sample the pre-edge value because rd_dat is taken from the current registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
         dout      <= '0;
      end else begin
         dout <= rd_dat;
         if (dec.cnt_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            instr_cnt <= instr_cnt + 32'(instr_retire);
         end
      end
   end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Queue-based reference model checked every cycle, plus directed vectors with literal expectations.
module tb_io_mmio_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_adr, mem_wdata;
   logic [3:0]  wea;
   logic        mem_re, instr_retire;
   logic [31:0] dout;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;

   int n_cmp = 0;
   int n_bad = 0;

   io_mmio_ctrl dut (
      .clk(clk), .reset(reset), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .wea(wea),
      .mem_re(mem_re), .instr_retire(instr_retire), .dout(dout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFOs as queues, counters as plain integers.
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   logic [31:0] m_cyc, m_ins, m_dout;
   bit          m_ok = 0;
   bit          pre_cyc = 0;

   always @(posedge clk) begin : model
      logic       hit, wr, rd, tpop, tpush, rpop, rpush;
      logic [7:0] off;
      logic [7:0] junk;
      if (reset) begin
         tx_q.delete();
         rx_q.delete();
         m_cyc  = 0;
         m_ins  = 0;
         m_dout = 0;
         m_ok   = 1;
      end else begin
         if (pre_cyc) m_cyc = 32'hFFFF_FFFF;
         hit   = (mem_adr[31:28] == 4'h8);
         off   = mem_adr[7:0];
         wr    = (wea != 4'h0);
         rd    = hit && mem_re && !wr;
         tpop  = (tx_q.size() != 0) && tx_ready;
         tpush = hit && wr && (off == 8'h08) && (tx_q.size() < 8 || tpop);
         rpush = rx_valid && (rx_q.size() < 8);
         rpop  = rd && (off == 8'h04) && (rx_q.size() != 0);
         m_dout = 0;
         if (rd) begin
            if (off == 8'h00) m_dout = {30'b0, rx_q.size() != 0, tx_q.size() < 8};
            if (off == 8'h04 && rpop) m_dout = {24'b0, rx_q[0]};
            if (off == 8'h10) m_dout = m_cyc;
            if (off == 8'h14) m_dout = m_ins;
         end
         if (hit && wr && off == 8'h18) begin
            m_cyc = 0;
            m_ins = 0;
         end else begin
            m_cyc = m_cyc + 1;
            m_ins = m_ins + {31'b0, instr_retire};
         end
         if (tpop)  junk = tx_q.pop_front();
         if (tpush) tx_q.push_back(mem_wdata[7:0]);
         if (rpop)  junk = rx_q.pop_front();
         if (rpush) rx_q.push_back(rx_data);
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("dout", dout, m_dout);
         check("tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
         if (tx_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, tx_q[0]});
         check("rx_ready", {31'b0, rx_ready}, {31'b0, rx_q.size() < 8});
      end
   end

   task automatic step();
      @(negedge clk);
      mem_adr = '0; mem_wdata = '0; wea = '0; mem_re = 0; instr_retire = 0; rx_valid = 0;
   endtask

   task automatic rd(input logic [31:0] a);
      mem_adr = a; mem_re = 1;
      step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_adr = a; mem_wdata = d; wea = 4'hF;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; tx_ready = 0; rx_data = 0;
      mem_adr = '0; mem_wdata = '0; wea = '0; mem_re = 0; instr_retire = 0; rx_valid = 0;
      step();
      check("reset_dout", dout, 32'd0);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("reset_rx_ready", {31'b0, rx_ready}, 32'd1);
      reset = 0;

      repeat (5) step();
      rd(32'h8000_0010);
      check("cyc_after_5", dout, 32'd5);
      rd(32'h8000_0000);
      check("ctrl_idle", dout, 32'h1);

      for (int i = 0; i < 9; i++) wr(32'h8000_0008, 32'h41 + i);
      rd(32'h8000_0000);
      check("ctrl_tx_full", dout, 32'h0);
      tx_ready = 1;
      for (int i = 0; i < 8; i++) begin
         check("tx_valid_drain", {31'b0, tx_valid}, 32'd1);
         check("tx_order", {24'b0, tx_data}, 32'h41 + i);
         step();
      end
      check("tx_empty_after", {31'b0, tx_valid}, 32'd0);
      tx_ready = 0;

      rx_data = 8'h5A; rx_valid = 1;
      step();
      rd(32'h8000_0004);
      check("rx_5a", dout, 32'h0000_005A);
      rd(32'h8000_0004);
      check("rx_empty_read", dout, 32'd0);
      rd(32'h8000_0000);
      check("ctrl_rx_empty", dout, 32'h1);

      // Push and pop on an empty RX FIFO in one cycle.
      rx_data = 8'h33; rx_valid = 1;
      rd(32'h8000_0004);
      check("rx_pushpop_empty", dout, 32'd0);
      rd(32'h8000_0004);
      check("rx_33", dout, 32'h33);

      for (int i = 0; i < 9; i++) begin
         rx_data = 8'h60 + 8'(i); rx_valid = 1;
         step();
      end
      check("rx_full_ready", {31'b0, rx_ready}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         rd(32'h8000_0004);
         check("rx_drain", dout, 32'h60 + i);
      end

      repeat (3) begin
         instr_retire = 1;
         step();
      end
      rd(32'h8000_0014);
      check("instr_3", dout, 32'd3);
      instr_retire = 1;
      wr(32'h8000_0018, 32'd0);
      step();
      rd(32'h8000_0014);
      check("instr_cleared", dout, 32'd0);

      mem_re = 1;
      wr(32'h8000_0010, 32'd0);
      check("write_wins_read", dout, 32'd0);
      rd(32'h9000_0010);
      check("unmapped_region", dout, 32'd0);
      rd(32'h8000_0020);
      check("unmapped_offset", dout, 32'd0);

      for (int i = 0; i < 8; i++) wr(32'h8000_0008, 32'h41 + i);
      tx_ready = 1;
      wr(32'h8000_0008, 32'h4A);
      tx_ready = 0;
      check("tx_full_pop_push_head", {24'b0, tx_data}, 32'h42);
      tx_ready = 1;
      repeat (8) step();
      check("tx_last_is_4a", {31'b0, tx_valid}, 32'd0);
      tx_ready = 0;

      force dut.cycle_cnt = 32'hFFFF_FFFF;
      pre_cyc = 1;
      #1;
      release dut.cycle_cnt;
      step();
      pre_cyc = 0;
      rd(32'h8000_0010);
      check("cyc_wrap", dout, 32'd0);

      for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'h70 + i);
      check("tx_pending", {31'b0, tx_valid}, 32'd1);
      tx_ready = 1; reset = 1;
      step();
      reset = 0;
      check("reset_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("reset_mid_dout", dout, 32'd0);
      check("reset_mid_rx_ready", {31'b0, rx_ready}, 32'd1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_mmio_ctrl.md
IO_MMIO_CTRL -- requirements
Module: io_mmio_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have mem_adr, input, 32, byte address from the core execute stage.
REQ-004 SHALL have mem_wdata, input, 32, store data from the core execute stage.
REQ-005 SHALL have wea, input, 4, byte write enables; any nonzero bit is a write.
REQ-006 SHALL have mem_re, input, 1, load request in the same cycle as mem_adr.
REQ-007 SHALL have instr_retire, input, 1, one pulse per retired instruction.
REQ-008 SHALL have dout, output, 32, registered read data, valid the cycle after mem_re.
REQ-009 SHALL have tx_data, output, 8, and tx_valid, output, 1, the byte stream to the UART transmitter.
REQ-010 SHALL have tx_ready, input, 1, UART transmitter accept.
REQ-011 SHALL have rx_data, input, 8, and rx_valid, input, 1, the byte stream from the UART receiver.
REQ-012 SHALL have rx_ready, output, 1, receiver accept; it equals "RX FIFO not full".

Function
REQ-013 Address decode SHALL be active only when mem_adr[31:28]==4'h8; the offset SHALL be mem_adr[7:0], and any other offset is unmapped.
REQ-014 Offset 0x00 read SHALL return {30'b0, rx_nonempty, tx_notfull}.
REQ-015 Offset 0x04 read SHALL return {24'b0, RX head byte} and pop the RX FIFO; a read while the FIFO is empty SHALL return 0 and SHALL NOT pop.
REQ-016 Offset 0x08 write SHALL push mem_wdata[7:0] into the TX FIFO.
- The push is dropped silently if the FIFO is full, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-017 Offset 0x10 read SHALL return cycle_cnt; offset 0x14 read SHALL return instr_cnt.
REQ-018 Offset 0x18 write SHALL zero both counters on the next edge; this zeroing overrides a same-cycle increment.
REQ-019 cycle_cnt SHALL increment every cycle, and instr_cnt SHALL increment on instr_retire; both are 32 bits and wrap from 0xFFFF_FFFF to 0.
REQ-020 dout SHALL be registered with 1-cycle latency.
- It SHALL be 0 for unmapped addresses or when mem_re=0.
- For counter reads, dout SHALL reflect the value before that edge's update.
REQ-021 TX and RX FIFOs SHALL each be 8 entries deep, first-word fall-through, with 3-bit pointers and a 4-bit count.
- Full is count==8; empty is count==0.
- Pointers wrap from 7 to 0.
REQ-022 A TX pop SHALL occur when tx_valid && tx_ready; tx_valid SHALL equal "TX FIFO nonempty"; tx_data SHALL equal the TX head.
REQ-023 An RX push SHALL occur when rx_valid && rx_ready.
- Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged.
- Simultaneous push and pop on an empty FIFO SHALL return 0 on the read and store the pushed byte.
REQ-024 If mem_re and wea are both nonzero in one cycle, the block SHALL perform the write and ignore the read.

Reset
REQ-025 Reset SHALL clear: all FIFO pointers and counts, cycle_cnt, instr_cnt, and dout.
- After reset: tx_valid=0, rx_ready=1, dout=0.
REQ-026 Reset asserted mid-transfer SHALL discard all FIFO contents; a tx_valid handshake pending in that cycle SHALL NOT pop.
REQ-027 FIFO storage arrays SHALL NOT require reset.

Structure
REQ-028 The following SHALL live in the shared defines package:
- address offsets: IO_UART_CTRL, IO_UART_RX, IO_UART_TX, IO_CYC_CNT, IO_INST_CNT, IO_CNT_RST;
- region tag 4'h8;
- FIFO depth 8.
REQ-029 A single parameterised sub-module, io_fifo (WIDTH, DEPTH), SHALL be instantiated twice (TX, RX).

Verification
REQ-030 Sequence: reset, then 5 idle cycles, then read 0x8000_0010 -> dout=5 one cycle later; read 0x8000_0000 -> dout=0x1.
REQ-031 TX fill: tx_ready=0, write 0x41..0x49 (9 bytes) to 0x8000_0008.
- Expect 8 stored; 0x49 dropped; ctrl bit0=0.
- Then tx_ready=1: expect 0x41..0x48 out in order on consecutive cycles.
REQ-032 RX: drive 0x5A with rx_valid for 1 cycle, then read 0x8000_0004.
- Expect dout=0x0000_005A; a second read returns 0; ctrl bit1=0.
REQ-033 Counters: pulse instr_retire 3 times, write 0x8000_0018 in the same cycle as a retire pulse.
- A read of 0x8000_0014 two cycles later SHALL return 0.
REQ-034 Wrap and reset: preload cycle_cnt=0xFFFF_FFFF, expect 0 after one edge.
- Assert reset with 4 bytes in TX FIFO and tx_ready=1: expect tx_valid=0 the cycle after reset.
